// File: rtl/multicycle_main_fsm_pkg.sv
// Shared definitions for the multi-cycle RV32I main control FSM.
// Contents:
//   - state encoding (S_FETCH..S_TRAP)
//   - supported opcodes
//   - ALUOp codes
//   - mux select codes for result_src, alu_src_a and alu_src_b
//   - a helper that tells whether an opcode is one the core executes
package multicycle_main_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // result mux
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // ALU A mux
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU B mux
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/multicycle_main_fsm_retire_counter.sv
// Retired-instruction bookkeeping for the multi-cycle core.
// Ports:
//   clk, rst_n  - clock / async active-low reset
//   i_retire    - an instruction completes on the coming edge
//   o_pulse     - registered one-cycle pulse, high in the first FETCH cycle
//   o_cnt       - CNT_W-bit retire count, wraps to 0
module multicycle_retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_retire,
  output logic             o_pulse,
  output logic [CNT_W-1:0] o_cnt
);

  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pulse <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_pulse <= i_retire;
      if (i_retire) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_pulse = r_pulse;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multi-cycle RV32I core (lw, sw, R, I, beq, jal).
// Moore machine: every control output is decoded from the current state,
// with mem_ready gating the FETCH strobes and zero gating the beq PC write.
// Ports:
//   clk, rst_n         - clock / async active-low reset
//   op                 - IR[6:0], looked at only in DECODE and MEMADR
//   zero               - ALU zero flag
//   mem_ready          - memory port finished its access this cycle
//   pc_write, adr_src, mem_write, ir_write, result_src,
//   alu_src_a, alu_src_b, alu_op, reg_write - datapath controls
//   instr_retired      - one-cycle pulse per completed instruction
//   retired_cnt        - retired-instruction count (wraps)
//   state_o            - current state, debug only (STATE_W >= 4)
//   illegal_o          - only with MULTICYCLE_ILLEGAL_TRAP_EN: parked in TRAP
// Build option MULTICYCLE_ILLEGAL_TRAP_EN: unsupported opcodes trap forever
// instead of being treated as a NOP.
module multicycle_main_fsm
  import multicycle_main_fsm_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               reg_write,
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  output logic               illegal_o,
`endif
  output logic               instr_retired,
  output logic [CNT_W-1:0]   retired_cnt,
  output logic [STATE_W-1:0] state_o
);

  state_e r_state;
  state_e w_next;
  logic   w_retire;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          default:      w_next = S_TRAP;
`else
          // unsupported opcode: silently skipped, nothing written
          default:      w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_TRAP:     w_next = S_TRAP;
`endif
      default:    w_next = S_FETCH;
    endcase
  end

  // output decode
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    reg_write  = 1'b0;
    w_retire   = 1'b0;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    illegal_o  = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        // PC+4 goes straight from the ALU through the result mux
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        // OldPC + imm: branch target ready for BEQ
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_RDATA;
        reg_write  = 1'b1;
        w_retire   = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        w_retire  = mem_ready;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        w_retire  = 1'b1;
      end
      S_BEQ: begin
        // ALUOut holds the target computed in DECODE
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        pc_write  = zero;
        w_retire  = 1'b1;
      end
      S_JAL: begin
        // ALUOut (target) -> PC while the ALU forms OldPC+4 for rd
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_TRAP: begin
        illegal_o = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  multicycle_retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_retire (w_retire),
    .o_pulse  (instr_retired),
    .o_cnt    (retired_cnt)
  );

  assign state_o = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_main_fsm.sv
module tb_multicycle_main_fsm;

  localparam int CW = 4;   // small counter so wrap-around is exercised

  // state codes as listed for the block
  localparam int T_FETCH = 0, T_DECODE = 1, T_MEMADR = 2, T_MEMREAD = 3,
                 T_MEMWB = 4, T_MEMWRITE = 5, T_EXECR = 6, T_EXECI = 7,
                 T_ALUWB = 8, T_BEQ = 9, T_JAL = 10, T_TRAP = 11;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    op = '0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0]    result_src, alu_src_a, alu_src_b, alu_op;
  logic          instr_retired;
  logic [CW-1:0] retired_cnt;
  logic [3:0]    state_o;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic          illegal_o;
`endif

  multicycle_main_fsm #(.CNT_W(CW), .STATE_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op            (op),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .adr_src       (adr_src),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .reg_write     (reg_write),
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    .illegal_o     (illegal_o),
`endif
    .instr_retired (instr_retired),
    .retired_cnt   (retired_cnt),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  logic [14:0] ctrl_act;
  assign ctrl_act = {pc_write, adr_src, mem_write, ir_write, result_src,
                     alu_src_a, alu_src_b, alu_op, reg_write};

  // expected controls straight from the per-state table
  function automatic logic [14:0] exp_ctrl(input int st, input logic mr, input logic z);
    logic pw, as, mw, iw, rw;
    logic [1:0] rs, sa, sb, ao;
    pw = 0; as = 0; mw = 0; iw = 0; rw = 0;
    rs = 2'd0; sa = 2'd0; sb = 2'd0; ao = 2'd0;
    case (st)
      T_FETCH:    begin sb = 2'd2; rs = 2'd2; iw = mr; pw = mr; end
      T_DECODE:   begin sa = 2'd1; sb = 2'd1; end
      T_MEMADR:   begin sa = 2'd2; sb = 2'd1; end
      T_MEMREAD:  begin as = 1; end
      T_MEMWB:    begin rs = 2'd1; rw = 1; end
      T_MEMWRITE: begin as = 1; mw = 1; end
      T_EXECR:    begin sa = 2'd2; ao = 2'd2; end
      T_EXECI:    begin sa = 2'd2; sb = 2'd1; ao = 2'd2; end
      T_ALUWB:    begin rw = 1; end
      T_BEQ:      begin sa = 2'd2; ao = 2'd1; pw = z; end
      T_JAL:      begin sa = 2'd1; sb = 2'd2; pw = 1; end
      default:    ;
    endcase
    return {pw, as, mw, iw, rs, sa, sb, ao, rw};
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BQ) || (o == JL);
  endfunction

  typedef struct { int st; bit mr; } step_t;
  step_t tr[$];

  int exp_cnt = 0;   // model count, modulo 2^CW
  bit pend    = 0;   // previous instruction retired -> pulse expected

  function automatic step_t mk(input int st, input bit mr);
    step_t s;
    s.st = st; s.mr = mr;
    return s;
  endfunction

  // Build the expected state path of one instruction, then drive/check it.
  // zsel: 0/1 force zero, 2 random. wf/wm: wait cycles in FETCH / memory state.
  task automatic run_instr(input logic [6:0] iop, input int zsel, input int wf, input int wm);
    bit legal;
    legal = is_legal(iop);
    tr.delete();
    for (int k = 0; k < wf; k++) tr.push_back(mk(T_FETCH, 0));
    tr.push_back(mk(T_FETCH, 1));
    tr.push_back(mk(T_DECODE, 1'($urandom)));
    case (iop)
      LW: begin
        tr.push_back(mk(T_MEMADR, 1'($urandom)));
        for (int k = 0; k < wm; k++) tr.push_back(mk(T_MEMREAD, 0));
        tr.push_back(mk(T_MEMREAD, 1));
        tr.push_back(mk(T_MEMWB, 1'($urandom)));
      end
      SW: begin
        tr.push_back(mk(T_MEMADR, 1'($urandom)));
        for (int k = 0; k < wm; k++) tr.push_back(mk(T_MEMWRITE, 0));
        tr.push_back(mk(T_MEMWRITE, 1));
      end
      RT: begin tr.push_back(mk(T_EXECR, 1'($urandom))); tr.push_back(mk(T_ALUWB, 1'($urandom))); end
      IT: begin tr.push_back(mk(T_EXECI, 1'($urandom))); tr.push_back(mk(T_ALUWB, 1'($urandom))); end
      BQ: tr.push_back(mk(T_BEQ, 1'($urandom)));
      JL: begin tr.push_back(mk(T_JAL, 1'($urandom))); tr.push_back(mk(T_ALUWB, 1'($urandom))); end
      default: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        for (int k = 0; k < 4; k++) tr.push_back(mk(T_TRAP, 1'($urandom)));
`endif
      end
    endcase
    foreach (tr[i]) begin
      // op only matters in DECODE/MEMADR: feed garbage elsewhere
      op        = (tr[i].st == T_DECODE || tr[i].st == T_MEMADR) ? iop : 7'($urandom);
      zero      = (zsel < 2) ? 1'(zsel) : 1'($urandom);
      mem_ready = tr[i].mr;
      @(negedge clk);
      chk("state",   32'(state_o), 32'(tr[i].st));
      chk("ctrl",    32'(ctrl_act), 32'(exp_ctrl(tr[i].st, mem_ready, zero)));
      chk("retired", 32'(instr_retired), 32'((i == 0) && pend));
      chk("cnt",     32'(retired_cnt), 32'(exp_cnt));
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      chk("illegal", 32'(illegal_o), 32'(tr[i].st == T_TRAP));
`endif
      @(posedge clk); #1;
    end
    pend = legal;
    if (legal) exp_cnt = (exp_cnt + 1) % (1 << CW);
  endtask

  function automatic logic [6:0] pick_op(input bit allow_illegal);
    logic [6:0] o;
    int r;
    r = $urandom_range(0, allow_illegal ? 6 : 5);
    case (r)
      0: o = LW; 1: o = SW; 2: o = RT; 3: o = IT; 4: o = BQ; 5: o = JL;
      default: begin
        o = 7'($urandom);
        while (is_legal(o)) o = 7'($urandom);
      end
    endcase
    return o;
  endfunction

  initial begin
    bit allow_ill;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    allow_ill = 0;
`else
    allow_ill = 1;
`endif
    // reset state
    #12;
    chk("rst_state", 32'(state_o), 32'(T_FETCH));
    chk("rst_cnt",   32'(retired_cnt), 32'd0);
    chk("rst_pulse", 32'(instr_retired), 32'd0);
    chk("rst_ctrl",  32'(ctrl_act), 32'(exp_ctrl(T_FETCH, 0, 0)));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // directed cases
    run_instr(RT, 2, 0, 0);
    run_instr(LW, 2, 2, 3);   // 10 cycles
    run_instr(BQ, 1, 0, 0);
    run_instr(BQ, 0, 0, 0);
    run_instr(SW, 2, 0, 2);   // mem_write held 3 cycles
    run_instr(IT, 2, 1, 0);
    run_instr(JL, 2, 0, 0);
`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
    run_instr(7'h7f, 2, 0, 0);
`endif

    // randomized mix
    for (int n = 0; n < 40; n++)
      run_instr(pick_op(allow_ill), 2, $urandom_range(0, 3), $urandom_range(0, 3));

    // async reset in the middle of a stalled MEMREAD
    op = LW; mem_ready = 1'b1;
    @(posedge clk); #1;            // FETCH -> DECODE
    mem_ready = 1'b0;
    @(posedge clk); #1;            // -> MEMADR
    @(posedge clk); #1;            // -> MEMREAD, stalled
    chk("pre_rst_state", 32'(state_o), 32'(T_MEMREAD));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state_o), 32'(T_FETCH));
    chk("arst_cnt",   32'(retired_cnt), 32'd0);
    chk("arst_pulse", 32'(instr_retired), 32'd0);
    chk("arst_ctrl",  32'(ctrl_act), 32'(exp_ctrl(T_FETCH, 0, 0)));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    exp_cnt = 0; pend = 0;

    run_instr(LW, 2, 0, 0);
    run_instr(RT, 2, 0, 0);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    run_instr(7'h7f, 2, 0, 0);     // parks in TRAP, count frozen
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_main_fsm.md
Name: multicycle_main_fsm

Overview:
- Main control FSM for the multi-cycle RV32I core variant.
- Sequences the shared ALU, register file, unified memory port, PC and IR over several cycles per instruction.
- Emits the 2-bit ALUOp consumed by the ALU decoder: 00 add, 01 subtract/compare, 10 funct-decoded.
- Supports lw, sw, R-type, I-type ALU, beq and jal. Handles memory wait states and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- STATE_W, 4, width of state encoding and of state_o.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  7  instruction opcode, IR[6:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory port completed the access this cycle.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address mux: 0 = PC, 1 = ALU result register.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR / OldPC enable.
- result_src  out  2  result mux: 00 ALUOut, 01 read data, 10 ALU result.
- alu_src_a  out  2  ALU A mux: 00 PC, 01 OldPC, 10 rs1 register.
- alu_src_b  out  2  ALU B mux: 00 rs2 register, 01 immediate, 10 constant 4.
- alu_op  out  2  to ALU decoder.
- reg_write  out  1  register file write enable.
- instr_retired  out  1  one-cycle pulse per completed instruction.
- retired_cnt  out  CNT_W  retired-instruction count.
- state_o  out  STATE_W  current state, for debug.

Behaviour:
- Moore FSM with one registered state. All control outputs are combinational from state, plus the mem_ready, zero and feature gating given below. Unlisted outputs are 0.
- Reset: state = FETCH (0), retired_cnt = 0, instr_retired = 0. Reset mid-instruction abandons the instruction; no partial writes follow.
- FETCH (0): adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write and pc_write are asserted only when mem_ready=1; the PC update is PC+4.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE (1): alu_src_a=01, alu_src_b=10... no: alu_src_a=01, alu_src_b=01, alu_op=00; precomputes the branch target. Next state by opcode:
  - 0000011 (lw) or 0100011 (sw) -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1100011 -> BEQ.
  - 1101111 -> JAL.
  - Any other opcode -> see Optional Feature.
- MEMADR (2): alu_src_a=10, alu_src_b=01, alu_op=00. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD (3): adr_src=1, result_src=00. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB (4): result_src=01, reg_write=1. Goes to FETCH and retires.
- MEMWRITE (5): adr_src=1, result_src=00, mem_write=1. mem_write is held every cycle until mem_ready=1; then goes to FETCH and retires.
- EXECR (6): alu_src_a=10, alu_src_b=00, alu_op=10. Goes to ALUWB.
- EXECI (7): alu_src_a=10, alu_src_b=01, alu_op=10. Goes to ALUWB.
- ALUWB (8): result_src=00, reg_write=1. Goes to FETCH and retires.
- BEQ (9): alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero. Goes to FETCH and retires whether or not the branch is taken.
- JAL (10): alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. Goes to ALUWB, which writes PC+4 to rd.
- Retire event: any transition into FETCH from MEMWB, MEMWRITE (with mem_ready), ALUWB or BEQ.
  - instr_retired is registered and goes high for exactly the first FETCH cycle after the event.
  - retired_cnt increments by 1 in the same edge and wraps from 2^CNT_W-1 to 0.
- Cycles per instruction with mem_ready tied to 1: lw 5, sw 4, R/I 4, beq 3, jal 4. Each wait cycle adds 1.
- op is sampled only in DECODE and MEMADR; its value in other states is ignored.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Enabled:
  - Adds port illegal_o (out, 1) and state TRAP (11).
  - An unsupported opcode in DECODE goes to TRAP.
  - TRAP asserts illegal_o=1 with all strobes 0, stays there until rst_n, and does not retire.
- Disabled:
  - No illegal_o port.
  - An unsupported opcode in DECODE goes to FETCH as a NOP: no writes, no retire pulse, not counted.

Decomposition:
- Shared package holds:
  - state encoding constants S_FETCH..S_TRAP;
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL;
  - ALUOp constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10;
  - mux select constants for result_src, alu_src_a and alu_src_b.
- One natural sub-module: multicycle_retire_counter (retire pulse register plus CNT_W counter). The FSM stays in the top module.

Test Plan:
- Reset: rst_n=0 asynchronously mid-MEMREAD -> state_o=0, retired_cnt=0 and all strobes 0 (except FETCH's muxes) immediately, without waiting for a clock edge.
- R-type: op=0110011, mem_ready=1 -> state sequence 0,1,6,8,0; alu_op=10 in state 6; reg_write=1 in state 8; instr_retired pulse; retired_cnt=1.
- lw with memory waits: op=0000011, mem_ready low 2 cycles in FETCH and 3 cycles in MEMREAD -> 10 cycles total, adr_src=1 in MEMREAD, reg_write only in MEMWB.
- beq: op=1100011 with zero=1 -> pc_write=1 in BEQ; with zero=0 -> pc_write=0. Both cases use alu_op=01 and retire (count +1 each).
- sw: op=0100011, mem_ready=0 for 2 cycles in MEMWRITE -> mem_write high 3 consecutive cycles; reg_write never asserted.
- Illegal opcode op=1111111: feature on -> state 11, illegal_o=1 held, count unchanged. Feature off -> back to 0 after DECODE, count unchanged.
